// File: rtl/adam_periph_spi_target.sv
// SPI target that exposes a byte-wide register file; command byte = {read, addr[6:0]}.
// Build option: define ADAM_SPI_TARGET_AUTOINC_EN to step the address after every data byte.
module adam_periph_spi_target #(
    parameter int NO_REGS = 16,
    localparam int AW = (NO_REGS > 1) ? $clog2(NO_REGS) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clock_phase_i,
    input  logic                 clock_polarity_i,
    input  logic                 data_order_i,
    input  logic                 sclk_i,
    output logic                 sclk_o,
    output logic                 sclk_mode_o,
    input  logic                 mosi_i,
    output logic                 mosi_o,
    output logic                 mosi_mode_o,
    input  logic                 ss_n_i,
    output logic                 ss_n_o,
    output logic                 ss_n_mode_o,
    output logic                 miso_o,
    output logic                 miso_mode_o,
    input  logic                 loc_wr_valid_i,
    input  logic [AW-1:0]        loc_wr_addr_i,
    input  logic [7:0]           loc_wr_data_i,
    output logic [8*NO_REGS-1:0] regs_o,
    output logic                 spi_wr_valid_o,
    output logic [6:0]           spi_wr_addr_o,
    output logic [7:0]           spi_wr_data_o
);

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    state_t      state_q, state_d;
    logic [2:0]  sclk_sync_q, ss_sync_q;
    logic [1:0]  mosi_sync_q;
    logic        cpha_q, cpol_q, lsb_q;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  rx_q, tx_q;
    logic        rw_q, miso_q;
    logic [6:0]  addr_q, addr_next, rd_sel;
    logic [7:0]  regs_q [NO_REGS];
    logic        wr_valid_q;
    logic [6:0]  wr_addr_q;
    logic [7:0]  wr_data_q;

    logic        trig, trig_prev, lead_edge, trail_edge, sample_edge, shift_edge;
    logic        ss_fall, ss_rise, active, byte_done, wr_commit, load_read, tx_first;
    logic [7:0]  rx_byte, rd_data, tx_load;
    logic [2:0]  tx_idx;

    assign sclk_o      = 1'b0;
    assign sclk_mode_o = 1'b0;
    assign mosi_o      = 1'b0;
    assign mosi_mode_o = 1'b0;
    assign ss_n_o      = 1'b0;
    assign ss_n_mode_o = 1'b0;

    // Synchronizers are left unreset so a held-low ss_n cannot fake a falling edge after reset.
    always_ff @(posedge clk_i) begin
        sclk_sync_q <= {sclk_sync_q[1:0], sclk_i};
        ss_sync_q   <= {ss_sync_q[1:0], ss_n_i};
        mosi_sync_q <= {mosi_sync_q[0], mosi_i};
    end

    assign trig        = sclk_sync_q[1] ^ cpol_q;
    assign trig_prev   = sclk_sync_q[2] ^ cpol_q;
    assign lead_edge   = trig & ~trig_prev;
    assign trail_edge  = ~trig & trig_prev;
    assign sample_edge = cpha_q ? trail_edge : lead_edge;
    assign shift_edge  = cpha_q ? lead_edge : trail_edge;
    assign ss_fall     = ~ss_sync_q[1] & ss_sync_q[2];
    assign ss_rise     = ss_sync_q[1] & ~ss_sync_q[2];
    assign active      = (state_q != IDLE) & ~ss_rise;
    assign byte_done   = active & sample_edge & (bit_cnt_q == 3'd7);
    assign rx_byte     = lsb_q ? {mosi_sync_q[1], rx_q[7:1]} : {rx_q[6:0], mosi_sync_q[1]};

`ifdef ADAM_SPI_TARGET_AUTOINC_EN
    assign addr_next = addr_q + 7'd1;
`else
    assign addr_next = addr_q;
`endif

    function automatic logic in_range(input logic [6:0] a);
        return {1'b0, a} < 8'(NO_REGS);
    endfunction

    assign wr_commit = byte_done & (state_q == DATA) & ~rw_q & in_range(addr_q);
    assign rd_sel    = (state_q == CMD) ? rx_byte[6:0] : addr_next;
    assign rd_data   = in_range(rd_sel) ? regs_q[rd_sel[AW-1:0]] : 8'h00;
    assign load_read = (state_q == CMD) ? rx_byte[7] : rw_q;
    assign tx_load   = load_read ? rd_data : 8'h00;
    assign tx_first  = lsb_q ? tx_load[0] : tx_load[7];
    assign tx_idx    = lsb_q ? bit_cnt_q : 3'd7 - bit_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (ss_fall) state_d = CMD;
            CMD:     if (ss_rise) state_d = IDLE; else if (byte_done) state_d = DATA;
            DATA:    if (ss_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        miso_mode_o = 1'b0;
        if (state_q != IDLE && !ss_sync_q[1]) miso_mode_o = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cpha_q     <= 1'b0;
            cpol_q     <= 1'b0;
            lsb_q      <= 1'b0;
            bit_cnt_q  <= 3'd0;
            rx_q       <= 8'h00;
            tx_q       <= 8'h00;
            rw_q       <= 1'b0;
            addr_q     <= 7'd0;
            miso_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= 7'd0;
            wr_data_q  <= 8'h00;
        end else begin
            wr_valid_q <= 1'b0;
            if (state_q == IDLE) begin
                cpha_q <= clock_phase_i;
                cpol_q <= clock_polarity_i;
                lsb_q  <= data_order_i;
            end
            if (state_q == IDLE && ss_fall) begin
                bit_cnt_q <= 3'd0;
                tx_q      <= 8'h00;
                miso_q    <= 1'b0;
            end else if (active && sample_edge) begin
                rx_q      <= rx_byte;
                bit_cnt_q <= bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    tx_q <= tx_load;
                    if (!cpha_q) miso_q <= tx_first;
                    if (state_q == CMD) begin
                        rw_q   <= rx_byte[7];
                        addr_q <= rx_byte[6:0];
                    end else begin
                        addr_q <= addr_next;
                    end
                    if (wr_commit) begin
                        wr_valid_q <= 1'b1;
                        wr_addr_q  <= addr_q;
                        wr_data_q  <= rx_byte;
                    end
                end
            end else if (active && shift_edge && (cpha_q || bit_cnt_q != 3'd0)) begin
                // In CPHA=0 the shift edge right after a byte boundary must keep the preloaded bit.
                miso_q <= tx_q[tx_idx];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int k = 0; k < NO_REGS; k++) regs_q[k] <= 8'h00;
        end else begin
            for (int k = 0; k < NO_REGS; k++) begin
                if (wr_commit && addr_q == 7'(k))
                    regs_q[k] <= rx_byte;
                else if (loc_wr_valid_i && loc_wr_addr_i == AW'(k))
                    regs_q[k] <= loc_wr_data_i;
            end
        end
    end

    for (genvar g = 0; g < NO_REGS; g++) begin : g_regs_flat
        assign regs_o[8*g +: 8] = regs_q[g];
    end

    assign miso_o         = miso_q;
    assign spi_wr_valid_o = wr_valid_q;
    assign spi_wr_addr_o  = wr_addr_q;
    assign spi_wr_data_o  = wr_data_q;

endmodule

// File: tb/tb_adam_periph_spi_target.sv
// Bench for adam_periph_spi_target: bit-banged SPI controller against a byte-level register model.
`timescale 1ns/1ps
module tb_adam_periph_spi_target;

    localparam int NREG = 16;
    localparam int H    = 6;

    logic clk = 1'b0, rst_n = 1'b0;
    logic cpha = 1'b0, cpol = 1'b0, lsb = 1'b0;
    logic sclk = 1'b0, mosi = 1'b0, ss_n = 1'b1;
    logic loc_wr_valid = 1'b0;
    logic [3:0] loc_wr_addr = 4'd0;
    logic [7:0] loc_wr_data = 8'h00;
    logic sclk_o, sclk_mode, mosi_o, mosi_mode, ss_n_o, ss_n_mode, miso, miso_mode;
    logic [8*NREG-1:0] regs;
    logic spi_wr_valid;
    logic [6:0] spi_wr_addr;
    logic [7:0] spi_wr_data;

    int n_checks = 0, n_fail = 0;
    logic [7:0] tx_buf [8];
    logic [7:0] rx_buf [8];
    logic [7:0] exp_miso [8];
    logic [7:0] model_regs [NREG];
    logic [22:0] pulses [$];
    logic [22:0] exp_pulses [$];

    adam_periph_spi_target #(.NO_REGS(NREG)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .clock_phase_i(cpha), .clock_polarity_i(cpol), .data_order_i(lsb),
        .sclk_i(sclk), .sclk_o(sclk_o), .sclk_mode_o(sclk_mode),
        .mosi_i(mosi), .mosi_o(mosi_o), .mosi_mode_o(mosi_mode),
        .ss_n_i(ss_n), .ss_n_o(ss_n_o), .ss_n_mode_o(ss_n_mode),
        .miso_o(miso), .miso_mode_o(miso_mode),
        .loc_wr_valid_i(loc_wr_valid), .loc_wr_addr_i(loc_wr_addr), .loc_wr_data_i(loc_wr_data),
        .regs_o(regs),
        .spi_wr_valid_o(spi_wr_valid), .spi_wr_addr_o(spi_wr_addr), .spi_wr_data_o(spi_wr_data)
    );

    always #5 clk = ~clk;

    // Record every write pulse together with the register value visible in that same cycle.
    always @(negedge clk) begin
        if (spi_wr_valid === 1'b1)
            pulses.push_back({spi_wr_addr, spi_wr_data,
                              (spi_wr_addr < NREG) ? regs[8*spi_wr_addr +: 8] : 8'h00});
    end

    function automatic logic [8*NREG-1:0] model_flat();
        logic [8*NREG-1:0] r;
        for (int k = 0; k < NREG; k++) r[8*k +: 8] = model_regs[k];
        return r;
    endfunction

    // Byte-level reference: command byte then data bytes, partial final byte never commits.
    task automatic model_frame(input int nbytes, input int last_bits);
        logic [6:0] a;
        logic rd;
        exp_pulses.delete();
        rd = tx_buf[0][7];
        a  = tx_buf[0][6:0];
        exp_miso[0] = 8'h00;
        for (int j = 1; j < nbytes; j++) begin
            if (j == nbytes - 1 && last_bits < 8) break;
            if (rd) begin
                exp_miso[j] = (a < NREG) ? model_regs[a] : 8'h00;
            end else begin
                exp_miso[j] = 8'h00;
                if (a < NREG) begin
                    model_regs[a] = tx_buf[j];
                    exp_pulses.push_back({a, tx_buf[j], tx_buf[j]});
                end
            end
`ifdef ADAM_SPI_TARGET_AUTOINC_EN
            a = a + 7'd1;
`endif
        end
    endtask

    task automatic half_wait(input bit hook);
        for (int k = 1; k <= H; k++) begin
            @(negedge clk);
            if (hook && k == 2) loc_wr_valid = 1'b1;
            if (hook && k == 3) loc_wr_valid = 1'b0;
        end
    endtask

    task automatic set_mode(input logic pol, input logic pha, input logic order);
        cpol = pol; cpha = pha; lsb = order; sclk = pol;
        repeat (8) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] mo, input int nbits, input bit hook,
                             output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            int b;
            b = lsb ? i : 7 - i;
            if (!cpha) begin
                mosi = mo[b];
                half_wait(1'b0);
                mi[b] = miso;
                sclk = ~cpol;
                half_wait(hook && i == 7);
                sclk = cpol;
            end else begin
                sclk = ~cpol;
                mosi = mo[b];
                half_wait(1'b0);
                mi[b] = miso;
                sclk = cpol;
                half_wait(hook && i == 7);
            end
        end
        if (!cpha) half_wait(1'b0);
    endtask

    task automatic do_frame(input int nbytes, input int last_bits, input bit collide);
        pulses.delete();
        ss_n = 1'b0;
        repeat (10) @(negedge clk);
        for (int j = 0; j < nbytes; j++)
            send_byte(tx_buf[j], (j == nbytes - 1) ? last_bits : 8, collide && j == nbytes - 1, rx_buf[j]);
        ss_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (6) @(negedge clk);
        n_checks++; if (regs !== '0) begin n_fail++; $display("FAIL reset_regs: got %h want 0", regs); end
        n_checks++; if (miso !== 1'b0) begin n_fail++; $display("FAIL reset_miso: got %b want 0", miso); end
        n_checks++; if (miso_mode !== 1'b0) begin n_fail++; $display("FAIL reset_miso_mode: got %b want 0", miso_mode); end
        n_checks++; if ({sclk_mode, mosi_mode, ss_n_mode, sclk_o, mosi_o, ss_n_o} !== 6'b0) begin
            n_fail++; $display("FAIL reset_pin_modes: got %b want 000000", {sclk_mode, mosi_mode, ss_n_mode, sclk_o, mosi_o, ss_n_o}); end
        n_checks++; if ({spi_wr_valid, spi_wr_addr, spi_wr_data} !== 16'h0) begin
            n_fail++; $display("FAIL reset_wr_port: got %h want 0", {spi_wr_valid, spi_wr_addr, spi_wr_data}); end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic_write();
        set_mode(1'b0, 1'b0, 1'b0);
        tx_buf[0] = 8'h03; tx_buf[1] = 8'h5A;
        model_frame(2, 8);
        do_frame(2, 8, 1'b0);
        n_checks++; if (pulses.size() != 1) begin n_fail++; $display("FAIL basic_pulse_count: got %0d want 1", pulses.size()); end
        if (pulses.size() > 0) begin
            n_checks++; if (pulses[0] !== {7'd3, 8'h5A, 8'h5A}) begin
                n_fail++; $display("FAIL basic_pulse: got %h want %h", pulses[0], {7'd3, 8'h5A, 8'h5A}); end
        end
        n_checks++; if (regs[31:24] !== 8'h5A) begin n_fail++; $display("FAIL basic_reg3: got %h want 5a", regs[31:24]); end
        n_checks++; if (regs !== model_flat()) begin n_fail++; $display("FAIL basic_regs: got %h want %h", regs, model_flat()); end
    endtask

    task automatic test_modes();
        for (int m = 0; m < 4; m++) begin
            set_mode(m[1], m[0], 1'b1);
            tx_buf[0] = 8'h02; tx_buf[1] = 8'hA5;
            model_frame(2, 8);
            do_frame(2, 8, 1'b0);
            n_checks++; if (pulses.size() != 1 || regs[23:16] !== 8'hA5) begin
                n_fail++; $display("FAIL mode%0d_write: pulses %0d reg2 %h want 1 a5", m, pulses.size(), regs[23:16]); end
            tx_buf[0] = 8'h82; tx_buf[1] = 8'($urandom);
            model_frame(2, 8);
            do_frame(2, 8, 1'b0);
            n_checks++; if (rx_buf[0] !== 8'h00) begin n_fail++; $display("FAIL mode%0d_cmd_miso: got %h want 00", m, rx_buf[0]); end
            n_checks++; if (rx_buf[1] !== 8'hA5) begin n_fail++; $display("FAIL mode%0d_read: got %h want a5", m, rx_buf[1]); end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            int nb;
            set_mode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            nb = $urandom_range(2, 4);
            tx_buf[0] = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 19))};
            if (it == 5) tx_buf[0][6:0] = 7'h7F;
            for (int j = 1; j < nb; j++) tx_buf[j] = 8'($urandom);
            model_frame(nb, 8);
            do_frame(nb, 8, 1'b0);
            n_checks++; if (pulses.size() != exp_pulses.size()) begin
                n_fail++; $display("FAIL rand%0d_pulse_count: got %0d want %0d", it, pulses.size(), exp_pulses.size()); end
            for (int p = 0; p < pulses.size() && p < exp_pulses.size(); p++) begin
                n_checks++; if (pulses[p] !== exp_pulses[p]) begin
                    n_fail++; $display("FAIL rand%0d_pulse%0d: got %h want %h", it, p, pulses[p], exp_pulses[p]); end
            end
            for (int j = 0; j < nb; j++) begin
                n_checks++; if (rx_buf[j] !== exp_miso[j]) begin
                    n_fail++; $display("FAIL rand%0d_miso%0d: got %h want %h", it, j, rx_buf[j], exp_miso[j]); end
            end
            n_checks++; if (regs !== model_flat()) begin n_fail++; $display("FAIL rand%0d_regs: got %h want %h", it, regs, model_flat()); end
        end
    endtask

    task automatic test_burst();
        set_mode(1'b0, 1'b0, 1'b0);
        tx_buf[0] = 8'h0E; tx_buf[1] = 8'h11; tx_buf[2] = 8'h22; tx_buf[3] = 8'h33;
        model_frame(4, 8);
        do_frame(4, 8, 1'b0);
`ifdef ADAM_SPI_TARGET_AUTOINC_EN
        n_checks++; if (pulses.size() != 2) begin n_fail++; $display("FAIL burst_pulses: got %0d want 2", pulses.size()); end
        n_checks++; if (regs[119:112] !== 8'h11 || regs[127:120] !== 8'h22) begin
            n_fail++; $display("FAIL burst_regs: got %h %h want 11 22", regs[119:112], regs[127:120]); end
`else
        n_checks++; if (pulses.size() != 3) begin n_fail++; $display("FAIL burst_pulses: got %0d want 3", pulses.size()); end
        n_checks++; if (regs[119:112] !== 8'h33) begin n_fail++; $display("FAIL burst_reg14: got %h want 33", regs[119:112]); end
`endif
        n_checks++; if (regs !== model_flat()) begin n_fail++; $display("FAIL burst_model: got %h want %h", regs, model_flat()); end
    endtask

    task automatic test_abort();
        set_mode(1'b0, 1'b1, 1'b0);
        tx_buf[0] = 8'h07; tx_buf[1] = 8'h3C;
        model_frame(2, 8);
        do_frame(2, 8, 1'b0);
        tx_buf[1] = 8'hC3;
        model_frame(2, 5);
        do_frame(2, 5, 1'b0);
        n_checks++; if (pulses.size() != 0) begin n_fail++; $display("FAIL abort_pulses: got %0d want 0", pulses.size()); end
        n_checks++; if (regs[63:56] !== 8'h3C) begin n_fail++; $display("FAIL abort_reg7: got %h want 3c", regs[63:56]); end
        model_frame(2, 8);
        do_frame(2, 8, 1'b0);
        n_checks++; if (pulses.size() != 1 || regs[63:56] !== 8'hC3) begin
            n_fail++; $display("FAIL abort_recover: pulses %0d reg7 %h want 1 c3", pulses.size(), regs[63:56]); end
    endtask

    task automatic test_local_and_collision();
        logic [7:0] d;
        set_mode(1'b0, 1'b0, 1'b0);
        d = 8'($urandom);
        @(negedge clk);
        loc_wr_addr = 4'd9; loc_wr_data = d; loc_wr_valid = 1'b1;
        @(negedge clk);
        loc_wr_valid = 1'b0;
        model_regs[9] = d;
        n_checks++; if (regs[79:72] !== d) begin n_fail++; $display("FAIL local_write: got %h want %h", regs[79:72], d); end
        loc_wr_addr = 4'd5; loc_wr_data = 8'h77;
        tx_buf[0] = 8'h05; tx_buf[1] = 8'h99;
        model_frame(2, 8);
        do_frame(2, 8, 1'b1);
        n_checks++; if (regs[47:40] !== 8'h99) begin n_fail++; $display("FAIL collision_reg5: got %h want 99", regs[47:40]); end
        n_checks++; if (regs !== model_flat()) begin n_fail++; $display("FAIL collision_regs: got %h want %h", regs, model_flat()); end
        tx_buf[0] = 8'hFF; tx_buf[1] = 8'h5C;
        model_frame(2, 8);
        do_frame(2, 8, 1'b0);
        n_checks++; if (rx_buf[1] !== 8'h00) begin n_fail++; $display("FAIL read_7f: got %h want 00", rx_buf[1]); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] rb;
        set_mode(1'b0, 1'b0, 1'b0);
        ss_n = 1'b0;
        repeat (10) @(negedge clk);
        send_byte(8'h04, 8, 1'b0, rb);
        send_byte(8'h6E, 3, 1'b0, rb);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < NREG; k++) model_regs[k] = 8'h00;
        n_checks++; if (regs !== '0) begin n_fail++; $display("FAIL midrst_regs: got %h want 0", regs); end
        n_checks++; if ({miso, miso_mode, spi_wr_valid} !== 3'b000) begin
            n_fail++; $display("FAIL midrst_outputs: got %b want 000", {miso, miso_mode, spi_wr_valid}); end
        n_checks++; if ({spi_wr_addr, spi_wr_data} !== 15'h0) begin
            n_fail++; $display("FAIL midrst_wr_port: got %h want 0", {spi_wr_addr, spi_wr_data}); end
        pulses.delete();
        send_byte(8'h6E, 5, 1'b0, rb);
        send_byte(8'h6E, 8, 1'b0, rb);
        ss_n = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++; if (pulses.size() != 0 || regs !== '0) begin
            n_fail++; $display("FAIL midrst_no_write: pulses %0d regs %h want 0", pulses.size(), regs); end
        tx_buf[0] = 8'h04; tx_buf[1] = 8'h6E;
        model_frame(2, 8);
        do_frame(2, 8, 1'b0);
        n_checks++; if (pulses.size() != 1 || regs !== model_flat()) begin
            n_fail++; $display("FAIL midrst_next_frame: pulses %0d regs %h want 1 %h", pulses.size(), regs, model_flat()); end
    endtask

    initial begin
        for (int k = 0; k < NREG; k++) model_regs[k] = 8'h00;
        test_reset();
        test_basic_write();
        test_modes();
        test_burst();
        test_abort();
        test_local_and_collision();
        test_random();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
